// File: rtl/stream_mux_nx1_if.sv
// Stream bundle for stream_mux_nx1: N_CH packed input channels, one registered output,
// plus the channel select and the bad-select pulse.
interface stream_mux_nx1_if #(
  parameter int N_CH = 4,
  parameter int DW   = 8
);
  localparam int SW = $clog2(N_CH);

  logic [SW-1:0]        sel;
  logic [N_CH*DW-1:0]   in_data;
  logic [N_CH-1:0]      in_valid;
  logic [N_CH-1:0]      in_last;
  logic [N_CH-1:0]      in_ready;
  logic [DW-1:0]        out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;
  logic [SW-1:0]        out_ch;
  logic                 sel_err;

  modport slave (
    input  sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ch, sel_err
  );

  modport master (
    output sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ch, sel_err
  );
endinterface

// File: rtl/stream_mux_nx1.sv
// N:1 packet-locked stream multiplexer with a single registered output slot.
// Optional round-robin arbitration replaces sel when MUX_RR_ARB_EN is defined.
module stream_mux_nx1 #(
  parameter int N_CH = 4,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_nx1_if.slave bus
);
  localparam int SW = $clog2(N_CH);

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_gnt, w_gnt_nxt;
  logic [DW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_out_last;
  logic [SW-1:0]   r_out_ch;
  logic            r_sel_err, w_sel_err_nxt;

  logic            w_slot_free;
  logic            w_idle_ok;
  logic [SW-1:0]   w_idle_cand;
  logic            w_cand_ok;
  logic [SW-1:0]   w_cand;
  logic [N_CH-1:0] w_in_ready;
  logic [DW-1:0]   w_cand_data;
  logic            w_cand_last;
  logic            w_accept;

  assign w_slot_free = ~r_out_valid | bus.out_ready;

`ifdef MUX_RR_ARB_EN
  logic [SW-1:0] r_rr_ptr;
  logic          w_unused_sel;

  assign w_unused_sel = ^bus.sel;

  // First valid channel strictly after the last winner, wrapping around.
  always_comb begin
    logic [SW-1:0] idx;
    w_idle_ok   = 1'b0;
    w_idle_cand = '0;
    idx         = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = SW'((int'(r_rr_ptr) + k) % N_CH);
      if (!w_idle_ok && bus.in_valid[idx]) begin
        w_idle_ok   = 1'b1;
        w_idle_cand = idx;
      end
    end
  end

  assign w_sel_err_nxt = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= SW'(N_CH - 1);
    end else if (w_accept && r_state == S_IDLE) begin
      r_rr_ptr <= w_cand;
    end
  end
`else
  assign w_idle_ok     = (int'(bus.sel) < N_CH);
  assign w_idle_cand   = bus.sel;
  assign w_sel_err_nxt = (r_state == S_IDLE) & ~w_idle_ok & (|bus.in_valid);
`endif

  // Candidate is the locked grant mid-packet, otherwise the idle choice.
  always_comb begin
    w_cand_ok   = w_idle_ok;
    w_cand      = w_idle_cand;
    if (r_state == S_LOCK) begin
      w_cand_ok = 1'b1;
      w_cand    = r_gnt;
    end
    w_in_ready  = '0;
    w_cand_data = '0;
    w_cand_last = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_cand == SW'(i)) begin
        w_in_ready[i] = w_cand_ok & w_slot_free;
        w_cand_data   = bus.in_data[i*DW +: DW];
        w_cand_last   = bus.in_last[i];
      end
    end
  end

  assign w_accept = |(w_in_ready & bus.in_valid);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    if (w_accept) begin
      if (w_cand_last) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_LOCK;
        w_gnt_nxt   = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel_err <= w_sel_err_nxt;
    end
  end

  // Output slot: reload on accept, drain on out_ready, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_cand_data;
      r_out_last  <= w_cand_last;
      r_out_ch    <= w_cand;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_ch    = r_out_ch;
  assign bus.sel_err   = r_sel_err;
endmodule

// File: tb/tb_stream_mux_nx1.sv
// Bench for stream_mux_nx1: directed scenarios plus randomized traffic against a
// packet-level reference model (N_CH=4), and a bad-select scenario on an N_CH=5 instance.
module tb_stream_mux_nx1;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_nx1_if #(.N_CH(4), .DW(8)) bus ();
  stream_mux_nx1_if #(.N_CH(5), .DW(8)) bus5 ();

  stream_mux_nx1 #(.N_CH(4), .DW(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  stream_mux_nx1 #(.N_CH(5), .DW(8)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: packet owner (-1 when free) and the one-beat output slot.
  int         m_owner = -1;
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = '0;
  bit         m_last  = 1'b0;
  int         m_ch    = 0;
  bit         m_err   = 1'b0;
  int         m_rr    = N - 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cand_of();
    if (m_owner >= 0) return m_owner;
`ifdef MUX_RR_ARB_EN
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (bus.in_valid[c[1:0]]) return c;
    end
    return -1;
`else
    if (int'(bus.sel) < N) return int'(bus.sel);
    return -1;
`endif
  endfunction

  function automatic logic [3:0] exp_ready();
    int c;
    logic [3:0] r;
    c = cand_of();
    r = '0;
    if (c >= 0 && (!m_valid || bus.out_ready)) r[c[1:0]] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_ch    <= 0;
      m_err   <= 1'b0;
      m_rr    <= N - 1;
    end else begin
      int c;
      c = cand_of();
`ifdef MUX_RR_ARB_EN
      m_err <= 1'b0;
`else
      m_err <= (m_owner < 0) && (int'(bus.sel) >= N) && (|bus.in_valid);
`endif
      if (c >= 0 && (!m_valid || bus.out_ready) && bus.in_valid[c[1:0]]) begin
        m_valid <= 1'b1;
        m_data  <= bus.in_data[c*8 +: 8];
        m_last  <= bus.in_last[c[1:0]];
        m_ch    <= c;
        m_owner <= bus.in_last[c[1:0]] ? -1 : c;
        if (m_owner < 0) m_rr <= c;
      end else if (bus.out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        check("m_out_data", 32'(bus.out_data), 32'(m_data));
        check("m_out_last", 32'(bus.out_last), 32'(m_last));
        check("m_out_ch",   32'(bus.out_ch),   32'(m_ch));
      end
      check("m_sel_err",  32'(bus.sel_err),  32'(m_err));
      check("m_in_ready", 32'(bus.in_ready), 32'(exp_ready()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.sel = '0; bus.in_data = '0; bus.in_valid = '0; bus.in_last = '0; bus.out_ready = 1'b1;
    bus5.sel = '0; bus5.in_data = '0; bus5.in_valid = '0; bus5.in_last = '0; bus5.out_ready = 1'b1;
    rst_n = 1'b0;
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_out_ch",    32'(bus.out_ch),    32'd0);
    check("rst_sel_err",   32'(bus.sel_err),   32'd0);
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

`ifdef MUX_RR_ARB_EN
    begin
      int rr_exp[5] = '{0, 1, 2, 3, 0};
      bus.in_valid = 4'b1111;
      bus.in_last  = 4'b1111;
      bus.in_data  = 32'h03020100;
      for (int k = 0; k < 5; k++) begin
        step();
        check("rr_out_ch",    32'(bus.out_ch),    32'(rr_exp[k]));
        check("rr_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid = '0;
      step();
      bus5.sel = 3'd7; bus5.in_valid = 5'b11111;
      step();
      step();
      check("rr_sel_err_tied", 32'(bus5.sel_err), 32'd0);
      bus5.in_valid = '0;
      step();
    end
`else
    // Bad select on the 5-channel instance
    bus5.sel = 3'd7; bus5.in_valid = 5'b11111;
    #1 check("bad_in_ready", 32'(bus5.in_ready), 32'd0);
    step();
    check("bad_out_valid", 32'(bus5.out_valid), 32'd0);
    check("bad_sel_err1",  32'(bus5.sel_err),   32'd1);
    step();
    check("bad_sel_err2",  32'(bus5.sel_err),   32'd1);
    check("bad_out_valid2", 32'(bus5.out_valid), 32'd0);
    bus5.in_valid = '0;
    step();
    check("bad_sel_err_off", 32'(bus5.sel_err), 32'd0);
    bus5.sel = 3'd4; bus5.in_valid = 5'b10000; bus5.in_last = 5'b10000;
    bus5.in_data[4*8 +: 8] = 8'h9C;
    #1 check("ch4_in_ready", 32'(bus5.in_ready), 32'b10000);
    step();
    check("ch4_out_valid", 32'(bus5.out_valid), 32'd1);
    check("ch4_out_ch",    32'(bus5.out_ch),    32'd4);
    check("ch4_out_data",  32'(bus5.out_data),  32'h9C);
    bus5.in_valid = '0;

    // Basic single-beat packet
    bus.sel = 2'd2; bus.in_valid = 4'b0100; bus.in_last = 4'b0100;
    bus.in_data[2*8 +: 8] = 8'hA5;
    #1 check("basic_in_ready", 32'(bus.in_ready), 32'b0100);
    step();
    check("basic_out_data", 32'(bus.out_data), 32'hA5);
    check("basic_out_last", 32'(bus.out_last), 32'd1);
    check("basic_out_ch",   32'(bus.out_ch),   32'd2);
    bus.in_valid = '0;
    #1 check("basic_in_ready2", 32'(bus.in_ready), 32'b0100);
    step();

    // Lock: ch1 three beats, sel moves to 3 after the first
    bus.sel = 2'd1; bus.in_valid = 4'b0010; bus.in_last = 4'b0000;
    bus.in_data[1*8 +: 8] = 8'h11;
    step();
    check("lock_b1_data", 32'(bus.out_data), 32'h11);
    check("lock_b1_ch",   32'(bus.out_ch),   32'd1);
    bus.sel = 2'd3; bus.in_valid = 4'b1010; bus.in_last = 4'b1000;
    bus.in_data[1*8 +: 8] = 8'h12; bus.in_data[3*8 +: 8] = 8'h33;
    #1 check("lock_in_ready", 32'(bus.in_ready), 32'b0010);
    step();
    check("lock_b2_data", 32'(bus.out_data), 32'h12);
    check("lock_b2_ch",   32'(bus.out_ch),   32'd1);
    bus.in_data[1*8 +: 8] = 8'h13; bus.in_last = 4'b1010;
    step();
    check("lock_b3_data", 32'(bus.out_data), 32'h13);
    check("lock_b3_ch",   32'(bus.out_ch),   32'd1);
    check("lock_b3_last", 32'(bus.out_last), 32'd1);
    bus.in_valid = 4'b1000;
    #1 check("lock_next_ready", 32'(bus.in_ready), 32'b1000);
    step();
    check("lock_ch3_data", 32'(bus.out_data), 32'h33);
    check("lock_ch3_ch",   32'(bus.out_ch),   32'd3);
    bus.in_valid = '0;
    step();

    // Backpressure
    bus.out_ready = 1'b0; bus.sel = 2'd0; bus.in_valid = 4'b0001; bus.in_last = 4'b0001;
    bus.in_data[7:0] = 8'h40;
    step();
    check("bp_cap_valid", 32'(bus.out_valid), 32'd1);
    check("bp_cap_data",  32'(bus.out_data),  32'h40);
    bus.in_data[7:0] = 8'h41;
    #1 check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_data", 32'(bus.out_data), 32'h40);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_rel_data", 32'(bus.out_data), 32'h41);
    bus.in_data[7:0] = 8'h42;
    step();
    check("bp_next_data", 32'(bus.out_data), 32'h42);
    bus.in_valid = '0;
    step();

    // Reset mid-packet
    bus.sel = 2'd1; bus.in_valid = 4'b0010; bus.in_last = 4'b0000;
    bus.in_data[1*8 +: 8] = 8'h55;
    step();
    check("rl_out_data", 32'(bus.out_data), 32'h55);
    #2 rst_n = 1'b0;
    #1 check("rl_async_valid", 32'(bus.out_valid), 32'd0);
    check("rl_async_data", 32'(bus.out_data), 32'd0);
    step();
    rst_n = 1'b1;
    bus.sel = 2'd3; bus.in_valid = 4'b1000; bus.in_last = 4'b1000;
    bus.in_data[3*8 +: 8] = 8'h77;
    #1 check("rl_in_ready", 32'(bus.in_ready), 32'b1000);
    step();
    check("rl_out_ch",   32'(bus.out_ch),   32'd3);
    check("rl_out_data", 32'(bus.out_data), 32'h77);
    bus.in_valid = '0;
    step();
`endif

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      bus.sel       = 2'($urandom_range(0, 3));
      bus.in_valid  = 4'($urandom);
      bus.in_data   = 32'($urandom);
      for (int i = 0; i < N; i++) bus.in_last[i] = ($urandom_range(0, 2) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
